// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: ALU writeback vs multi-cycle unit, with ALU hold FIFO and MC anti-starvation.
// Optional performance counters are compiled in when WB_PERF_CNT_EN is defined.
module wb_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int SEL_W      = 5,
  parameter int HOLD_DEPTH = 4,
  parameter int MAX_WAIT   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] S3_Result,
  input  logic [SEL_W-1:0]  S3_WriteSelect,
  input  logic              S3_WriteEnable,
  input  logic              MC_Valid,
  input  logic [DATA_W-1:0] MC_Result,
  input  logic [SEL_W-1:0]  MC_WriteSelect,
  output logic              MC_Ready,
  output logic [DATA_W-1:0] RF_WriteData,
  output logic [SEL_W-1:0]  RF_WriteSelect,
  output logic              RF_WriteEnable,
  output logic              Pipe_Stall,
  output logic              Hold_Overflow
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0]       Perf_Conflicts,
  output logic [31:0]       Perf_Forced,
  output logic [31:0]       Perf_StallCycles
`endif
);

  localparam int PTR_W  = $clog2(HOLD_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int ENT_W  = SEL_W + DATA_W;

  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(HOLD_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_STALL = CNT_W'(HOLD_DEPTH - 2);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);

  logic [ENT_W-1:0]  mem_q [HOLD_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              ovf_q, ovf_d;
  logic              stall_q, stall_d;
  logic              rf_we_q, rf_we_d;
  logic [SEL_W-1:0]  rf_sel_q, rf_sel_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;

  logic              fifo_empty;
  logic              alu_cand;
  logic              conflict;
  logic              forced;
  logic              grant_mc;
  logic              grant_alu;
  logic              push;
  logic              push_ok;
  logic              pop;
  logic [ENT_W-1:0]  cand;

  always_comb begin
    fifo_empty = (count_q == '0);
    alu_cand   = !fifo_empty || S3_WriteEnable;
    // Once anything is held, the FIFO head is the oldest ALU write and must go first.
    cand       = fifo_empty ? {S3_WriteSelect, S3_Result} : mem_q[rd_ptr_q];
    conflict   = !rst && alu_cand && MC_Valid;
    forced     = conflict && (wait_q == WAIT_MAX);
    grant_mc   = !rst && MC_Valid && (!alu_cand || forced);
    grant_alu  = !rst && alu_cand && !grant_mc;
    pop        = grant_alu && !fifo_empty;
    push       = !rst && S3_WriteEnable && (!fifo_empty || grant_mc);
    push_ok    = push && ((count_q != CNT_FULL) || pop);

    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d   = wr_ptr_q + PTR_W'(push_ok);
    count_d    = count_q + CNT_W'(push_ok) - CNT_W'(pop);
    ovf_d      = ovf_q || (push && !push_ok);
    stall_d    = (count_d >= CNT_STALL);

    wait_d = wait_q;
    if (!MC_Valid || grant_mc) begin
      wait_d = '0;
    end else if (wait_q != WAIT_MAX) begin
      wait_d = wait_q + WAIT_W'(1);
    end

    rf_we_d = grant_mc || grant_alu;
    if (grant_mc) begin
      {rf_sel_d, rf_data_d} = {MC_WriteSelect, MC_Result};
    end else begin
      {rf_sel_d, rf_data_d} = cand;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      wait_q    <= '0;
      ovf_q     <= 1'b0;
      stall_q   <= 1'b0;
      rf_we_q   <= 1'b0;
      rf_sel_q  <= '0;
      rf_data_q <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      wait_q    <= wait_d;
      ovf_q     <= ovf_d;
      stall_q   <= stall_d;
      rf_we_q   <= rf_we_d;
      rf_sel_q  <= rf_sel_d;
      rf_data_q <= rf_data_d;
    end
  end

  // Storage needs no reset: count_q alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= {S3_WriteSelect, S3_Result};
    end
  end

  assign MC_Ready       = grant_mc;
  assign RF_WriteEnable = rf_we_q;
  assign RF_WriteSelect = rf_sel_q;
  assign RF_WriteData   = rf_data_q;
  assign Pipe_Stall     = stall_q;
  assign Hold_Overflow  = ovf_q;

`ifdef WB_PERF_CNT_EN
  logic [31:0] perf_conf_q, perf_forced_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_conf_q   <= '0;
      perf_forced_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_conf_q   <= perf_conf_q + 32'(conflict);
      perf_forced_q <= perf_forced_q + 32'(forced);
      perf_stall_q  <= perf_stall_q + 32'(stall_q);
    end
  end

  assign Perf_Conflicts   = perf_conf_q;
  assign Perf_Forced      = perf_forced_q;
  assign Perf_StallCycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed vector table, corner sequences and random traffic
// against a queue-based reference model. Perf counters are checked when WB_PERF_CNT_EN is defined.
module tb_wb_port_arbiter;
  localparam int DW = 32;
  localparam int SW = 5;
  localparam int HD = 4;
  localparam int MW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] S3_Result;
  logic [SW-1:0] S3_WriteSelect;
  logic          S3_WriteEnable;
  logic          MC_Valid;
  logic [DW-1:0] MC_Result;
  logic [SW-1:0] MC_WriteSelect;
  logic          MC_Ready;
  logic [DW-1:0] RF_WriteData;
  logic [SW-1:0] RF_WriteSelect;
  logic          RF_WriteEnable;
  logic          Pipe_Stall;
  logic          Hold_Overflow;
`ifdef WB_PERF_CNT_EN
  logic [31:0]   Perf_Conflicts, Perf_Forced, Perf_StallCycles;
`endif

  always #5 clk = ~clk;

  wb_port_arbiter #(.DATA_W(DW), .SEL_W(SW), .HOLD_DEPTH(HD), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .S3_Result(S3_Result), .S3_WriteSelect(S3_WriteSelect), .S3_WriteEnable(S3_WriteEnable),
    .MC_Valid(MC_Valid), .MC_Result(MC_Result), .MC_WriteSelect(MC_WriteSelect),
    .MC_Ready(MC_Ready),
    .RF_WriteData(RF_WriteData), .RF_WriteSelect(RF_WriteSelect), .RF_WriteEnable(RF_WriteEnable),
    .Pipe_Stall(Pipe_Stall), .Hold_Overflow(Hold_Overflow)
`ifdef WB_PERF_CNT_EN
    , .Perf_Conflicts(Perf_Conflicts), .Perf_Forced(Perf_Forced), .Perf_StallCycles(Perf_StallCycles)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: hold FIFO as a queue of {sel,data}, plus the MC wait streak.
  logic [SW+DW-1:0] q[$];
  int               m_wait;
  bit               m_ovf;
  bit               e_ready, e_we, e_stall;
  logic [SW-1:0]    e_sel;
  logic [DW-1:0]    e_data;
  int unsigned      m_conf, m_forced, m_stallcyc;
  logic             last_ready;

  task automatic model_reset();
    q.delete();
    m_wait = 0; m_ovf = 0;
    e_ready = 0; e_we = 0; e_stall = 0; e_sel = '0; e_data = '0;
    m_conf = 0; m_forced = 0; m_stallcyc = 0;
  endtask

  task automatic model_cycle(input logic we, input logic [SW-1:0] sel, input logic [DW-1:0] d,
                             input logic mv, input logic [SW-1:0] msel, input logic [DW-1:0] md);
    bit alu_has, mc_win;
    alu_has = (q.size() > 0) || we;
    mc_win  = mv && (!alu_has || m_wait == MW);
    if (alu_has && mv) m_conf++;
    if (alu_has && mv && mc_win) m_forced++;
    if (e_stall) m_stallcyc++;
    e_ready = mc_win;
    if (mc_win) begin
      e_we = 1; e_sel = msel; e_data = md;
      if (we) begin
        if (q.size() == HD) m_ovf = 1;
        else q.push_back({sel, d});
      end
    end else if (alu_has) begin
      e_we = 1;
      if (q.size() > 0) begin
        {e_sel, e_data} = q.pop_front();
        if (we) q.push_back({sel, d});
      end else begin
        e_sel = sel; e_data = d;
      end
    end else begin
      e_we = 0;
    end
    if (!mv || mc_win) m_wait = 0;
    else if (m_wait < MW) m_wait++;
    e_stall = (q.size() >= HD - 2);
  endtask

  // Called at posedge+1; drives one cycle of inputs, checks MC_Ready mid-cycle and RF_* after the edge.
  task automatic step(input logic we, input logic [SW-1:0] sel, input logic [DW-1:0] d,
                      input logic mv, input logic [SW-1:0] msel, input logic [DW-1:0] md);
    S3_WriteEnable = we; S3_WriteSelect = sel; S3_Result = d;
    MC_Valid = mv; MC_WriteSelect = msel; MC_Result = md;
    @(negedge clk);
    model_cycle(we, sel, d, mv, msel, md);
    last_ready = MC_Ready;
    check("mc_ready", MC_Ready, e_ready);
    @(posedge clk); #1;
    check("rf_we", RF_WriteEnable, e_we);
    if (e_we) begin
      check("rf_sel", RF_WriteSelect, e_sel);
      check("rf_data", RF_WriteData, e_data);
    end
    check("pipe_stall", Pipe_Stall, e_stall);
    check("hold_overflow", Hold_Overflow, m_ovf);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check("rst_rf_we", RF_WriteEnable, 0);
      check("rst_rf_sel", RF_WriteSelect, 0);
      check("rst_rf_data", RF_WriteData, 0);
      check("rst_stall", Pipe_Stall, 0);
      check("rst_ovf", Hold_Overflow, 0);
      check("rst_mc_ready", MC_Ready, 0);
    end
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic          we;
    logic [SW-1:0] sel;
    logic [DW-1:0] d;
    logic          mv;
    logic [SW-1:0] msel;
    logic [DW-1:0] md;
    logic          x_ready;
    logic          x_we;
    logic [SW-1:0] x_sel;
    logic [DW-1:0] x_data;
    logic          x_stall;
  } vec_t;

  vec_t vt[11];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  initial begin
    int n_wr;
    logic          mv_r;
    logic [SW-1:0] msel_r;
    logic [DW-1:0] md_r;

    vt[0]  = '{1'b1, 5'd1,  32'h10, 1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 5'd1,  32'h10, 1'b0};
    vt[1]  = '{1'b1, 5'd2,  32'h11, 1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 5'd2,  32'h11, 1'b0};
    vt[2]  = '{1'b1, 5'd3,  32'h12, 1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 5'd3,  32'h12, 1'b0};
    vt[3]  = '{1'b1, 5'd4,  32'h13, 1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 5'd4,  32'h13, 1'b0};
    vt[4]  = '{1'b0, 5'd0,  32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 5'd0,  32'h0,  1'b0};
    vt[5]  = '{1'b1, 5'd10, 32'h20, 1'b1, 5'd9, 32'h99, 1'b0, 1'b1, 5'd10, 32'h20, 1'b0};
    vt[6]  = '{1'b1, 5'd11, 32'h21, 1'b1, 5'd9, 32'h99, 1'b0, 1'b1, 5'd11, 32'h21, 1'b0};
    vt[7]  = '{1'b1, 5'd12, 32'h22, 1'b1, 5'd9, 32'h99, 1'b0, 1'b1, 5'd12, 32'h22, 1'b0};
    vt[8]  = '{1'b1, 5'd13, 32'h23, 1'b1, 5'd9, 32'h99, 1'b1, 1'b1, 5'd9,  32'h99, 1'b0};
    vt[9]  = '{1'b0, 5'd0,  32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 5'd13, 32'h23, 1'b0};
    vt[10] = '{1'b0, 5'd0,  32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 5'd0,  32'h0,  1'b0};

    S3_WriteEnable = 0; S3_WriteSelect = '0; S3_Result = '0;
    MC_Valid = 0; MC_WriteSelect = '0; MC_Result = '0;
    last_ready = 0;
    model_reset();
    do_reset(2);

    // Reset in the middle of traffic with a held entry, then first write after release.
    for (int k = 0; k < 4; k++) step(1'b1, 5'd3, 32'h33 + k, 1'b1, 5'd4, 32'h44);
    do_reset(3);
    step(1'b1, 5'd7, 32'hA5, 1'b0, 5'd0, 32'h0);
    check("t1_first_we", RF_WriteEnable, 1);
    check("t1_first_sel", RF_WriteSelect, 7);
    check("t1_first_data", RF_WriteData, 32'hA5);
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Directed vectors: ALU-only burst, then MC starvation forcing a push and drain.
    for (int i = 0; i < 11; i++) begin
      step(vt[i].we, vt[i].sel, vt[i].d, vt[i].mv, vt[i].msel, vt[i].md);
      check("vec_ready", last_ready, vt[i].x_ready);
      check("vec_we", RF_WriteEnable, vt[i].x_we);
      if (vt[i].x_we) begin
        check("vec_sel", RF_WriteSelect, vt[i].x_sel);
        check("vec_data", RF_WriteData, vt[i].x_data);
      end
      check("vec_stall", Pipe_Stall, vt[i].x_stall);
    end

    // Two forced MC wins back up two ALU writes: stall rises, then falls after one drain.
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 5'(k + 16), 32'h100 + k, 1'b1, 5'd9, 32'h900 + k);
      if (k == 6) check("t4_stall_low", Pipe_Stall, 0);
    end
    check("t4_stall_rise", Pipe_Stall, 1);
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    check("t4_stall_fall", Pipe_Stall, 0);
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Five forced pushes into a 4-deep FIFO with stall ignored.
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 5'(k + 1), 32'h200 + k, 1'b1, 5'd10, 32'hA0 + k);
      if (k == 18) check("t5_ovf_low", Hold_Overflow, 0);
    end
    check("t5_ovf_set", Hold_Overflow, 1);
    n_wr = 0;
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      if (RF_WriteEnable) n_wr++;
    end
    check("t5_drain_count", n_wr, 4);
    check("t5_ovf_sticky", Hold_Overflow, 1);

`ifdef WB_PERF_CNT_EN
    do_reset(1);
    for (int k = 0; k < 10; k++) step(1'b1, 5'd5, 32'h300 + k, 1'b1, 5'd6, 32'h600 + k);
    check("t6_conflicts", Perf_Conflicts, 10);
    check("t6_forced", Perf_Forced, 2);
`endif

    // Random traffic; MC keeps its request stable until granted.
    do_reset(1);
    mv_r = 0; msel_r = '0; md_r = '0;
    for (int c = 0; c < 500; c++) begin
      if (!mv_r) begin
        mv_r   = ($urandom_range(0, 99) < 40);
        msel_r = 5'($urandom);
        md_r   = $urandom;
      end
      step(1'($urandom_range(0, 99) < ((c / 100) % 2 == 0 ? 60 : 30)), 5'($urandom), $urandom,
           mv_r, msel_r, md_r);
      if (e_ready) mv_r = 0;
    end
`ifdef WB_PERF_CNT_EN
    check("perf_conflicts", Perf_Conflicts, m_conf);
    check("perf_forced", Perf_Forced, m_forced);
    check("perf_stall", Perf_StallCycles, m_stallcyc);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
